// File: rtl/mux_rr_arbiter_pkg.sv
// mux_arb_pkg: shared types and helpers for the round-robin mux arbiter.
// Contents: state_t (IDLE/GRANT), sel_width/cnt_width sizing helpers,
// rr_next(ptr, mask, n) returning the first set mask index at or after ptr.
package mux_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic int sel_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction
  // Supports up to eight requesters; returns ptr when mask is empty.
  function automatic logic [2:0] rr_next(input logic [2:0] ptr, input logic [7:0] mask, input int n);
    logic [2:0] idx;
    logic hit;
    int j;
    idx = ptr;
    hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      j = (int'(ptr) + k) % n;
      if (k < n && !hit && mask[3'(j)]) begin
        idx = 3'(j);
        hit = 1'b1;
      end
    end
    return idx;
  endfunction
endpackage

// File: rtl/mux_rr_arbiter_pick.sv
// rr_pick: combinational requester pick, round-robin from ptr or fixed priority.
// Ports: mask[N] candidates, ptr start index, idx chosen index, any = mask nonzero.
// MUX_ARB_FIXED_PRIO_EN selects lowest-index-wins and ignores ptr.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);
  assign any = |mask;
`ifdef MUX_ARB_FIXED_PRIO_EN
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (mask[i]) idx = W'(i);
  end
`else
  logic [7:0] m8;
  assign m8  = 8'(mask);
  assign idx = W'(rr_next(3'(ptr), m8, N));
`endif
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin burst arbiter driving a registered N:1 valid/ready mux.
// Ports: clk; rst (async, active-low); req_valid/req_data/req_ready per requester
// (lane i at req_data[i*DW +: DW]); out_valid/out_data/out_ready registered output;
// sel granted index (holds after release); grant one-hot, zero while idle.
// MUX_ARB_FIXED_PRIO_EN: idle pick is the lowest valid index instead of round-robin.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int DW       = 1,
  parameter int MAXBURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DW-1:0]         req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       out_valid,
  output logic [DW-1:0]              out_data,
  input  logic                       out_ready,
  output logic [sel_width(NREQ)-1:0] sel,
  output logic [NREQ-1:0]            grant
);
  localparam int SEL_W = sel_width(NREQ);
  localparam int CNT_W = cnt_width(MAXBURST);
  state_t state, state_nxt;
  logic [SEL_W-1:0] ptr, pick;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0] lane [NREQ];
  logic any, space, acc, rel;
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane[i] = req_data[i*DW +: DW];
  end
  rr_pick #(.N(NREQ), .W(SEL_W)) u_pick (
    .mask(req_valid),
    .ptr (ptr),
    .idx (pick),
    .any (any)
  );
  // grant is zero outside GRANT, so masking it with space gives req_ready directly.
  always_comb begin
    space     = !out_valid || out_ready;
    req_ready = space ? grant : '0;
    acc       = |(req_valid & req_ready);
    rel       = state == GRANT && ((acc && cnt == CNT_W'(MAXBURST - 1)) || (space && !req_valid[sel]));
    state_nxt = state == IDLE ? (any ? GRANT : IDLE) : (rel ? IDLE : GRANT);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sel   <= '0;
      grant <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (any) begin
        sel   <= pick;
        grant <= NREQ'(1) << pick;
        cnt   <= '0;
      end
    end else begin
      if (acc) cnt <= cnt + 1'b1;
      if (rel) begin
        grant <= '0;
        ptr   <= sel == SEL_W'(NREQ - 1) ? '0 : sel + 1'b1;
      end
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data  <= lane[sel];
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: vector table, corner sequences and random traffic against a reference model.
module tb_mux_rr_arbiter;
  localparam int N = 3;
  localparam int DW = 4;
  localparam int MB = 4;
  logic clk, rst, out_ready, out_valid;
  logic [N-1:0] req_valid, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0] out_data;
  logic [1:0] sel;
  int checks, failures;
  int m_busy, m_g, m_cnt, m_ptr, m_ov;
  logic [DW-1:0] m_od;
  logic [N-1:0] prev_g;
  int gq[$];
  typedef struct {
    logic [2:0] rv;
    logic [3:0] d;
    logic       ordy;
    logic [2:0] eg;
    logic [2:0] er;
    logic       eov;
    logic [3:0] eod;
    logic [1:0] esel;
  } vec_t;
  vec_t tv[9];
  int exp_rot[4];
  mux_rr_arbiter #(.NREQ(N), .DW(DW), .MAXBURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .sel(sel), .grant(grant)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask
  function automatic int m_pick(input logic [2:0] rv);
`ifdef MUX_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (rv[k]) return k;
`else
    for (int k = 0; k < N; k++) if (rv[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
    return 0;
  endfunction
  task automatic m_update(input logic [2:0] rv, input logic [11:0] rd, input logic ordy);
    bit space, acc;
    space = !m_ov || ordy;
    acc = m_busy != 0 && space && rv[m_g];
    if (acc) begin
      m_ov = 1;
      m_od = rd[m_g*DW +: DW];
    end else if (ordy) m_ov = 0;
    if (m_busy == 0) begin
      if (rv != 0) begin
        m_g = m_pick(rv);
        m_busy = 1;
        m_cnt = 0;
      end
    end else begin
      if (acc) m_cnt++;
      if ((acc && m_cnt == MB) || (space && !rv[m_g])) begin
        m_busy = 0;
        m_ptr = (m_g + 1) % N;
      end
    end
  endtask
  task automatic m_reset();
    m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0; m_ov = 0; m_od = '0; prev_g = '0;
  endtask
  task automatic do_reset();
    rst = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    m_reset();
    gq.delete();
    rst = 1'b1;
  endtask
  task automatic step(input logic [2:0] rv, input logic [11:0] rd, input logic ordy);
    logic [2:0] eg;
    req_valid = rv; req_data = rd; out_ready = ordy;
    #1;
    eg = m_busy != 0 ? 3'(1 << m_g) : 3'b000;
    chk("grant", 32'(grant), 32'(eg));
    chk("sel", 32'(sel), 32'(m_g));
    chk("req_ready", 32'(req_ready), (m_ov == 0 || ordy) ? 32'(eg) : 32'd0);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    if (grant != 0 && prev_g == 0) gq.push_back(int'(grant));
    prev_g = grant;
    @(posedge clk);
    m_update(rv, rd, ordy);
    @(negedge clk);
  endtask
  task automatic chk_seq(input string nm, input int n);
    for (int i = 0; i < n; i++) chk($sformatf("%s%0d", nm, i), i < gq.size() ? gq[i] : 0, exp_rot[i]);
  endtask
  function automatic logic [11:0] rnd_data();
    return 12'($urandom);
  endfunction
  initial begin
    checks = 0; failures = 0;
    tv[0] = '{3'b010, 4'h9, 1'b1, 3'b000, 3'b000, 1'b0, 4'h0, 2'd0};
    tv[1] = '{3'b010, 4'h9, 1'b1, 3'b010, 3'b010, 1'b0, 4'h0, 2'd1};
    tv[2] = '{3'b010, 4'h2, 1'b1, 3'b010, 3'b010, 1'b1, 4'h9, 2'd1};
    tv[3] = '{3'b010, 4'hB, 1'b1, 3'b010, 3'b010, 1'b1, 4'h2, 2'd1};
    tv[4] = '{3'b010, 4'h7, 1'b1, 3'b010, 3'b010, 1'b1, 4'hB, 2'd1};
    tv[5] = '{3'b010, 4'h4, 1'b1, 3'b000, 3'b000, 1'b1, 4'h7, 2'd1};
    tv[6] = '{3'b010, 4'h4, 1'b1, 3'b010, 3'b010, 1'b0, 4'h7, 2'd1};
    tv[7] = '{3'b000, 4'h0, 1'b1, 3'b010, 3'b010, 1'b1, 4'h4, 2'd1};
    tv[8] = '{3'b000, 4'h0, 1'b1, 3'b000, 3'b000, 1'b0, 4'h4, 2'd1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      req_valid = tv[i].rv; req_data = {4'hF, tv[i].d, 4'hE}; out_ready = tv[i].ordy;
      #1;
      chk($sformatf("tv%0d_grant", i), 32'(grant), 32'(tv[i].eg));
      chk($sformatf("tv%0d_ready", i), 32'(req_ready), 32'(tv[i].er));
      chk($sformatf("tv%0d_ov", i), 32'(out_valid), 32'(tv[i].eov));
      chk($sformatf("tv%0d_od", i), 32'(out_data), 32'(tv[i].eod));
      chk($sformatf("tv%0d_sel", i), 32'(sel), 32'(tv[i].esel));
      @(negedge clk);
    end
    do_reset();
    repeat (3) step(3'b111, rnd_data(), 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_od", 32'(out_data), 0);
    @(negedge clk);
    chk("rst_hold_grant", 32'(grant), 0);
    m_reset();
    rst = 1'b1;
    repeat (4) step(3'b111, rnd_data(), 1'b1);
    do_reset();
    step(3'b010, rnd_data(), 1'b1);
    step(3'b010, rnd_data(), 1'b1);
    repeat (3) step(3'b010, rnd_data(), 1'b0);
    repeat (2) step(3'b011, rnd_data(), 1'b0);
    step(3'b001, rnd_data(), 1'b0);
    step(3'b001, rnd_data(), 1'b1);
    repeat (3) step(3'b011, rnd_data(), 1'b1);
    do_reset();
    repeat (3) step(3'b011, rnd_data(), 1'b1);
    step(3'b010, rnd_data(), 1'b1);
    repeat (2) step(3'b010, rnd_data(), 1'b1);
    exp_rot = '{1, 2, 0, 0};
    chk_seq("early", 2);
    do_reset();
    repeat (24) step(3'b011, rnd_data(), 1'b1);
`ifdef MUX_ARB_FIXED_PRIO_EN
    exp_rot = '{1, 1, 1, 1};
`else
    exp_rot = '{1, 2, 1, 2};
`endif
    chk_seq("contend", 4);
    do_reset();
    repeat (22) step(3'b111, rnd_data(), 1'b1);
`ifdef MUX_ARB_FIXED_PRIO_EN
    exp_rot = '{1, 1, 1, 1};
`else
    exp_rot = '{1, 2, 4, 1};
`endif
    chk_seq("allvalid", 4);
    do_reset();
    repeat (3000) step(3'($urandom), rnd_data(), ($urandom % 4) != 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
